// File: rtl/matrix_sub_seq.sv
// Sequential element-wise subtractor for packed ROWS x COLS matrices (result = A - B, wrapping).
// One element is processed per clock under a start/busy/done handshake, with a per-element borrow mask.
module matrix_sub_seq #(
  parameter int ELEM_W = 8,
  parameter int ROWS   = 5,
  parameter int COLS   = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ROWS*COLS*ELEM_W-1:0]    matrix_a,
  input  logic [ROWS*COLS*ELEM_W-1:0]    matrix_b,
  output logic                           busy,
  output logic                           done,
  output logic [ROWS*COLS*ELEM_W-1:0]    result,
  output logic [ROWS*COLS-1:0]           borrow
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic                  state_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic                  done_reg;
  logic [N*ELEM_W-1:0]   a_reg;
  logic [N*ELEM_W-1:0]   b_reg;
  logic                  accept;

  // A start arriving during the done cycle is accepted, since state is already IDLE.
  assign accept = (state_reg == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        a_reg     <= matrix_a;
        b_reg     <= matrix_b;
        idx_reg   <= '0;
        state_reg <= RUN;
      end else if (state_reg == RUN) begin
        if (idx_reg == LAST_IDX) begin
          idx_reg   <= '0;
          state_reg <= IDLE;
          done_reg  <= 1'b1;
        end else begin
          idx_reg <= idx_reg + IDX_W'(1);
        end
      end
    end
  end

  // Each lane owns its result slice and borrow bit; only the lane selected by idx writes.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [ELEM_W-1:0] a_elem;
      logic [ELEM_W-1:0] b_elem;
      logic [ELEM_W-1:0] diff_reg;
      logic              borrow_reg;

      assign a_elem = a_reg[gi*ELEM_W +: ELEM_W];
      assign b_elem = b_reg[gi*ELEM_W +: ELEM_W];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          diff_reg   <= '0;
          borrow_reg <= 1'b0;
        end else if (accept) begin
          diff_reg   <= '0;
          borrow_reg <= 1'b0;
        end else if ((state_reg == RUN) && (idx_reg == IDX_W'(gi))) begin
          diff_reg   <= a_elem - b_elem;
          borrow_reg <= (a_elem < b_elem);
        end
      end

      assign result[gi*ELEM_W +: ELEM_W] = diff_reg;
      assign borrow[gi]                  = borrow_reg;
    end
  endgenerate

  assign busy = (state_reg == RUN);
  assign done = done_reg;

endmodule

// File: tb/tb_matrix_sub_seq.sv
// Directed bench for matrix_sub_seq: a counter/array model checked every cycle,
// plus literal expectations for each scenario.
module tb_matrix_sub_seq;

  localparam int ELEM_W = 8;
  localparam int ROWS   = 5;
  localparam int COLS   = 5;
  localparam int N      = ROWS * COLS;
  localparam int W      = N * ELEM_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  matrix_a = '0;
  logic [W-1:0]  matrix_b = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [N-1:0]  borrow;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  matrix_sub_seq #(.ELEM_W(ELEM_W), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .matrix_a (matrix_a),
    .matrix_b (matrix_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .borrow   (borrow)
  );

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] fill(input logic [7:0] v);
    return {N{v}};
  endfunction

  // Model: captured operands, count of finished elements, count of elements still to go.
  int m_a[N];
  int m_b[N];
  int m_k = 0;
  int m_left = 0;
  bit m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0;
      m_left = 0;
      m_done = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_a[i] = 0;
        m_b[i] = 0;
      end
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (start) begin
          for (int i = 0; i < N; i++) begin
            m_a[i] = int'(matrix_a[i*ELEM_W +: ELEM_W]);
            m_b[i] = int'(matrix_b[i*ELEM_W +: ELEM_W]);
          end
          m_k = 0;
          m_left = N;
        end
      end else begin
        m_k++;
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [W-1:0] exp_r;
      logic [W-1:0] exp_b;
      exp_r = '0;
      exp_b = '0;
      for (int i = 0; i < N; i++) begin
        if (i < m_k) begin
          exp_r[i*ELEM_W +: ELEM_W] = 8'(m_a[i] - m_b[i]);
          exp_b[i] = (m_a[i] < m_b[i]);
        end
      end
      check_int("cyc_busy", longint'(busy), longint'(m_left > 0));
      check_int("cyc_done", longint'(done), longint'(m_done));
      check_int("cyc_busy_and_done", longint'(busy & done), 0);
      check_vec("cyc_result", result, exp_r);
      check_vec("cyc_borrow", W'(borrow), exp_b);
    end
  end

  // Pulse start for one edge, then count edges until done is seen (expected 25).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(posedge clk); #1;
    matrix_a = a;
    matrix_b = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL run_timeout got=no_done want=done t=%0t", $time);
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int first;
    logic [W-1:0] va;
    logic [W-1:0] sum;

    repeat (2) @(posedge clk);
    cmp_en = 1'b1;
    #1;
    check_int("reset_busy", longint'(busy), 0);
    check_int("reset_done", longint'(done), 0);
    check_vec("reset_result", result, '0);
    check_vec("reset_borrow", W'(borrow), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1) uniform 5 - 3
    run_op(fill(8'h05), fill(8'h03), lat);
    check_int("t1_latency", lat, 25);
    check_vec("t1_result", result, fill(8'h02));
    check_vec("t1_borrow", W'(borrow), '0);
    @(posedge clk); #1;
    check_int("t1_done_one_cycle", longint'(done), 0);

    // 2) a[i]=i, b=1: only element 0 borrows
    va = '0;
    for (int i = 0; i < N; i++) va[i*ELEM_W +: ELEM_W] = 8'(i);
    run_op(va, fill(8'h01), lat);
    check_int("t2_latency", lat, 25);
    check_int("t2_elem0", longint'(result[7:0]), 8'hFF);
    check_int("t2_elem1", longint'(result[15:8]), 8'h00);
    check_int("t2_elem24", longint'(result[24*ELEM_W +: ELEM_W]), 8'd23);
    check_int("t2_borrow", longint'(borrow), 25'h0000001);

    // 3) 0x80 - 0xFF wraps to 0x81 everywhere; adding b back must give a
    run_op(fill(8'h80), fill(8'hFF), lat);
    check_vec("t3_result", result, fill(8'h81));
    check_int("t3_borrow", longint'(borrow), 25'h1FFFFFF);
    for (int i = 0; i < N; i++)
      sum[i*ELEM_W +: ELEM_W] = result[i*ELEM_W +: ELEM_W] + 8'hFF;
    check_vec("t3_inverse", sum, fill(8'h80));

    // 4) input changes and a start pulse while busy are ignored
    @(posedge clk); #1;
    matrix_a = fill(8'h10);
    matrix_b = fill(8'h01);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; ndone = 0; first = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        ndone++;
        if (first == 0) first = lat;
      end
      if (lat == 5) begin
        matrix_a = fill(8'hAA);
        matrix_b = fill(8'h55);
        start = 1'b1;
      end
      if (lat == 6) start = 1'b0;
    end
    check_int("t4_done_count", ndone, 1);
    check_int("t4_done_at", first, 25);
    check_vec("t4_result", result, fill(8'h0F));

    // 5) reset in the middle of a run
    @(posedge clk); #1;
    matrix_a = fill(8'h44);
    matrix_b = fill(8'h11);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("t5_rst_busy", longint'(busy), 0);
    check_int("t5_rst_done", longint'(done), 0);
    check_vec("t5_rst_result", result, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check_int("t5_no_done", ndone, 0);
    run_op(fill(8'h07), fill(8'h02), lat);
    check_int("t5_latency", lat, 25);
    check_vec("t5_result", result, fill(8'h05));

    // 6) start held through the done cycle: back-to-back runs 26 cycles apart
    @(posedge clk); #1;
    matrix_a = fill(8'h33);
    matrix_b = fill(8'h11);
    start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_int("t6_first_latency", lat, 25);
    check_vec("t6_first_result", result, fill(8'h22));
    matrix_a = fill(8'h20);
    matrix_b = fill(8'h30);
    @(posedge clk); #1;
    check_int("t6_accept_busy", longint'(busy), 1);
    check_int("t6_accept_done", longint'(done), 0);
    check_vec("t6_accept_cleared", result, '0);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_int("t6_done_spacing", lat, 26);
    check_vec("t6_second_result", result, fill(8'hF0));
    check_int("t6_second_borrow", longint'(borrow), 25'h1FFFFFF);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
